// File: rtl/ball_motion_pkg.sv
// Shared settings for the breakout ball controller: screen geometry, reset
// position, state encoding and the position clamp used by both axes.
package ball_motion_pkg;

    localparam int POS_W           = 10;
    localparam int DEF_SCREEN_W    = 640;
    localparam int DEF_SCREEN_H    = 480;
    localparam int DEF_BALL_RADIUS = 10;
    localparam int DEF_FLOOR_Y     = 470;
    localparam int RESET_X         = 320;
    localparam int RESET_Y         = 400;
    localparam int SERVE_LIFT      = 31;

    typedef enum logic [1:0] {
        SERVE = 2'd0,
        MOVE  = 2'd1,
        LOST  = 2'd2,
        OVER  = 2'd3
    } state_t;

    // Clamp a signed 11-bit candidate position into [lo, hi].
    function automatic logic [POS_W-1:0] clamp_pos(input logic signed [POS_W:0] v,
                                                   input int lo, input int hi);
        logic signed [POS_W:0] lo_s;
        logic signed [POS_W:0] hi_s;
        logic signed [POS_W:0] r;
        lo_s = (POS_W+1)'(lo);
        hi_s = (POS_W+1)'(hi);
        if (v < lo_s) begin
            r = lo_s;
        end else if (v > hi_s) begin
            r = hi_s;
        end else begin
            r = v;
        end
        return r[POS_W-1:0];
    endfunction

endpackage

// File: rtl/ball_motion_axis_bounce.sv
// One axis of ball motion: direction and cooldown state, crash-flag reversal
// and the clamped next position. Instantiated once for x and once for y.
module axis_bounce
    import ball_motion_pkg::*;
#(
    parameter int   STEP     = 2,
    parameter int   COOLDOWN = 2,
    parameter int   LO       = 10,
    parameter int   HI       = 630,
    parameter logic INIT_NEG = 1'b0,
    parameter logic EXIT_EN  = 1'b0,
    parameter int   EXIT_AT  = 1023
) (
    input  logic             iFrame_CLK,
    input  logic             iRST_n,
    input  logic             en,
    input  logic             launch,
    input  logic             neg_flag,
    input  logic             pos_flag,
    input  logic [POS_W-1:0] pos,
    output logic [POS_W-1:0] next_pos,
    output logic             reversed,
    output logic             past_limit
);

    localparam int CW = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN + 1);
    localparam logic signed [POS_W:0] STEP_S = (POS_W+1)'(STEP);

    logic                     dir_neg;
    logic                     dir_neg_nxt;
    logic [CW-1:0]            cool;
    logic                     cool_idle;
    logic                     flip;
    logic signed [POS_W:0]    stepped;

    assign cool_idle = (cool == '0);

    // A lone flag on the side the ball is heading toward reverses it; a flag
    // opposing the motion, or both flags together, is ignored.
    always_comb begin
        // NOTE: give every always_comb output a default first so no path can
        // leave it unassigned and infer a latch.
        flip = 1'b0;
        if (cool_idle && (neg_flag != pos_flag)) begin
            flip = dir_neg ? neg_flag : pos_flag;
        end
    end

    assign reversed    = en & flip;
    assign dir_neg_nxt = dir_neg ^ reversed;
    assign stepped     = $signed({1'b0, pos}) + (dir_neg_nxt ? -STEP_S : STEP_S);
    assign next_pos    = clamp_pos(stepped, LO, HI);
    assign past_limit  = EXIT_EN && !dir_neg && (pos >= POS_W'(EXIT_AT));

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge iFrame_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            dir_neg <= INIT_NEG;
            cool    <= '0;
        end else if (launch) begin
            dir_neg <= INIT_NEG;
            cool    <= '0;
        end else if (en) begin
            dir_neg <= dir_neg_nxt;
            if (reversed) begin
                cool <= CW'(COOLDOWN);
            end else if (!cool_idle) begin
                cool <= cool - CW'(1);
            end
        end
    end

endmodule

// File: rtl/ball_motion.sv
// Breakout ball controller: serve / move / lost / over sequencing, lives,
// slider tracking while serving, floor loss detection and the bounce pulse.
module ball_motion
    import ball_motion_pkg::*;
#(
    parameter int STEP        = 2,
    parameter int START_LIVES = 3,
    parameter int COOLDOWN    = 2,
    parameter int BALL_RADIUS = DEF_BALL_RADIUS,
    parameter int SCREEN_W    = DEF_SCREEN_W,
    parameter int SCREEN_H    = DEF_SCREEN_H,
    parameter int FLOOR_Y     = DEF_FLOOR_Y
) (
    input  logic             iFrame_CLK,
    input  logic             iRST_n,
    input  logic [3:0]       iCrash,
    input  logic             iLaunch,
    input  logic [POS_W-1:0] iSlider_x,
    input  logic [POS_W-1:0] iSlider_y,
    output logic [POS_W-1:0] oBall_x,
    output logic [POS_W-1:0] oBall_y,
    output logic [1:0]       oLives,
    output logic             oServing,
    output logic             oGame_over,
    output logic             oBounce
);

    localparam logic signed [POS_W:0] RADIUS_S = (POS_W+1)'(BALL_RADIUS);

    state_t                state;
    state_t                state_nxt;
    logic [POS_W-1:0]      next_x;
    logic [POS_W-1:0]      next_y;
    logic                  rev_x;
    logic                  rev_y;
    logic                  exit_x;
    logic                  exit_y;
    logic                  floor_hit;
    logic                  axis_en;
    logic                  launch_go;
    logic [1:0]            lives_dec;
    logic signed [POS_W:0] lifted;
    logic [POS_W-1:0]      serve_y;

    // Only the y axis has an exit edge (the floor); x never reports one.
    assign floor_hit = (state == MOVE) && (exit_x || exit_y);
    assign axis_en   = (state == MOVE) && !floor_hit;
    assign launch_go = (state == SERVE) && iLaunch;
    assign lives_dec = (oLives == 2'd0) ? 2'd0 : oLives - 2'd1;

    assign lifted  = $signed({1'b0, iSlider_y} - (POS_W+1)'(SERVE_LIFT));
    assign serve_y = (lifted < RADIUS_S) ? POS_W'(BALL_RADIUS) : lifted[POS_W-1:0];

    axis_bounce #(
        .STEP     (STEP),
        .COOLDOWN (COOLDOWN),
        .LO       (BALL_RADIUS),
        .HI       (SCREEN_W - BALL_RADIUS),
        .INIT_NEG (1'b0),
        .EXIT_EN  (1'b0),
        .EXIT_AT  (SCREEN_W)
    ) u_axis_x (
        .iFrame_CLK (iFrame_CLK),
        .iRST_n     (iRST_n),
        .en         (axis_en),
        .launch     (launch_go),
        .neg_flag   (iCrash[3]),
        .pos_flag   (iCrash[2]),
        .pos        (oBall_x),
        .next_pos   (next_x),
        .reversed   (rev_x),
        .past_limit (exit_x)
    );

    axis_bounce #(
        .STEP     (STEP),
        .COOLDOWN (COOLDOWN),
        .LO       (BALL_RADIUS),
        .HI       (SCREEN_H - BALL_RADIUS),
        .INIT_NEG (1'b1),
        .EXIT_EN  (1'b1),
        .EXIT_AT  (FLOOR_Y)
    ) u_axis_y (
        .iFrame_CLK (iFrame_CLK),
        .iRST_n     (iRST_n),
        .en         (axis_en),
        .launch     (launch_go),
        .neg_flag   (iCrash[1]),
        .pos_flag   (iCrash[0]),
        .pos        (oBall_y),
        .next_pos   (next_y),
        .reversed   (rev_y),
        .past_limit (exit_y)
    );

    always_ff @(posedge iFrame_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state <= SERVE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SERVE:   if (iLaunch) state_nxt = MOVE;
            MOVE:    if (floor_hit) state_nxt = LOST;
            LOST:    state_nxt = (lives_dec == 2'd0) ? OVER : SERVE;
            OVER:    if (iLaunch) state_nxt = SERVE;
            default: state_nxt = SERVE;
        endcase
    end

    always_comb begin
        oServing   = 1'b0;
        oGame_over = 1'b0;
        case (state)
            SERVE:   oServing   = 1'b1;
            OVER:    oGame_over = 1'b1;
            default: ;
        endcase
    end

    // Position and lives; the ball is held in LOST, OVER and on the floor frame.
    always_ff @(posedge iFrame_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            oBall_x <= POS_W'(RESET_X);
            oBall_y <= POS_W'(RESET_Y);
            oLives  <= 2'(START_LIVES);
            oBounce <= 1'b0;
        end else begin
            oBounce <= rev_x | rev_y;
            case (state)
                SERVE: begin
                    oBall_x <= iSlider_x;
                    oBall_y <= serve_y;
                end
                MOVE: begin
                    if (!floor_hit) begin
                        oBall_x <= next_x;
                        oBall_y <= next_y;
                    end
                end
                LOST: oLives <= lives_dec;
                OVER: if (iLaunch) oLives <= 2'(START_LIVES);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ball_motion.sv
// Scoreboard bench for ball_motion: a frame-level reference model predicts the
// outputs after every frame; a monitor pops and compares them on the falling edge.
module tb_ball_motion;

    localparam int STEP        = 2;
    localparam int START_LIVES = 3;
    localparam int COOLDOWN    = 2;
    localparam int RADIUS      = 10;
    localparam int MAX_X       = 630;
    localparam int MAX_Y       = 470;
    localparam int FLOOR       = 470;

    logic       frame_clk = 1'b0;
    logic       rst_n;
    logic [3:0] crash;
    logic       launch;
    logic [9:0] slider_x;
    logic [9:0] slider_y;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic [1:0] lives;
    logic       serving;
    logic       game_over;
    logic       bounce;

    always #5 frame_clk = ~frame_clk;

    ball_motion #(
        .STEP        (STEP),
        .START_LIVES (START_LIVES),
        .COOLDOWN    (COOLDOWN)
    ) dut (
        .iFrame_CLK (frame_clk),
        .iRST_n     (rst_n),
        .iCrash     (crash),
        .iLaunch    (launch),
        .iSlider_x  (slider_x),
        .iSlider_y  (slider_y),
        .oBall_x    (ball_x),
        .oBall_y    (ball_y),
        .oLives     (lives),
        .oServing   (serving),
        .oGame_over (game_over),
        .oBounce    (bounce)
    );

    typedef enum {M_SERVE, M_MOVE, M_LOST, M_OVER} mode_e;

    typedef struct {
        int    x;
        int    y;
        int    lives;
        bit    serving;
        bit    over;
        bit    bounce;
        string tag;
    } exp_t;

    exp_t  sb_q[$];
    event  sample_ev;
    int    checks = 0;
    int    errors = 0;

    mode_e m_mode;
    int    m_x, m_y, m_dx, m_dy, m_cx, m_cy, m_lives;
    bit    m_bounce;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    // One axis per frame: a lone flag toward the direction of travel reverses
    // it when no cooldown is running; the cooldown otherwise counts down.
    task automatic axis_rule(input bit nflag, input bit pflag, inout int dir, inout int cool, output bit rev);
        rev = 1'b0;
        if (cool == 0 && nflag && !pflag && dir == -1) begin
            dir = 1;
            rev = 1'b1;
        end else if (cool == 0 && pflag && !nflag && dir == 1) begin
            dir = -1;
            rev = 1'b1;
        end
        if (rev) cool = COOLDOWN;
        else if (cool > 0) cool--;
    endtask

    task automatic model_reset();
        m_mode   = M_SERVE;
        m_x      = 320;
        m_y      = 400;
        m_dx     = 1;
        m_dy     = -1;
        m_cx     = 0;
        m_cy     = 0;
        m_lives  = START_LIVES;
        m_bounce = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] c, input bit l, input int sx, input int sy);
        bit rx, ry;
        m_bounce = 1'b0;
        case (m_mode)
            M_SERVE: begin
                m_x = sx;
                m_y = (sy - 31 < RADIUS) ? RADIUS : sy - 31;
                if (l) begin
                    m_dx = 1; m_dy = -1; m_cx = 0; m_cy = 0;
                    m_mode = M_MOVE;
                end
            end
            M_MOVE: begin
                if (m_y >= FLOOR && m_dy == 1) begin
                    m_mode = M_LOST;
                end else begin
                    axis_rule(c[3], c[2], m_dx, m_cx, rx);
                    axis_rule(c[1], c[0], m_dy, m_cy, ry);
                    m_x = clampi(m_x + STEP * m_dx, RADIUS, MAX_X);
                    m_y = clampi(m_y + STEP * m_dy, RADIUS, MAX_Y);
                    m_bounce = rx | ry;
                end
            end
            M_LOST: begin
                m_lives = (m_lives > 0) ? m_lives - 1 : 0;
                m_mode  = (m_lives == 0) ? M_OVER : M_SERVE;
            end
            M_OVER: begin
                if (l) begin
                    m_lives = START_LIVES;
                    m_mode  = M_SERVE;
                end
            end
        endcase
    endtask

    task automatic push_exp(input string tag);
        exp_t e;
        e.x       = m_x;
        e.y       = m_y;
        e.lives   = m_lives;
        e.serving = (m_mode == M_SERVE);
        e.over    = (m_mode == M_OVER);
        e.bounce  = m_bounce;
        e.tag     = tag;
        sb_q.push_back(e);
    endtask

    // Drive one frame's inputs, predict the post-edge outputs, queue them.
    task automatic frame(input logic [3:0] c, input bit l, input int sx, input int sy, input string tag);
        crash    = c;
        launch   = l;
        slider_x = 10'(sx);
        slider_y = 10'(sy);
        model_step(c, l, sx, sy);
        @(posedge frame_clk);
        #1;
        push_exp(tag);
    endtask

    // Assert reset between edges and have the monitor sample before any edge.
    task automatic reset_now(input string tag);
        #6;
        rst_n = 1'b0;
        model_reset();
        push_exp(tag);
        #1;
        -> sample_ev;
        @(posedge frame_clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic lose_ball();
        frame(4'b0000, 1'b1, 320, 460, "lose_launch");
        for (int i = 0; i < 800 && m_mode != M_LOST; i++) begin
            frame((m_dy == -1) ? 4'b0010 : 4'b0000, 1'b0, 320, 460, "lose_run");
        end
        check("lose_ball_bound", 32'(m_mode == M_LOST), 32'd1);
        frame(4'b0000, 1'b0, 320, 460, "lost_exit");
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge frame_clk or sample_ev);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check({e.tag, ".x"},         32'(ball_x),    32'(e.x));
                check({e.tag, ".y"},         32'(ball_y),    32'(e.y));
                check({e.tag, ".lives"},     32'(lives),     32'(e.lives));
                check({e.tag, ".serving"},   32'(serving),   32'(e.serving));
                check({e.tag, ".game_over"}, 32'(game_over), 32'(e.over));
                check({e.tag, ".bounce"},    32'(bounce),    32'(e.bounce));
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rst_n    = 1'b0;
        crash    = 4'b0000;
        launch   = 1'b0;
        slider_x = 10'd320;
        slider_y = 10'd460;
        model_reset();
        push_exp("reset");
        @(posedge frame_clk); #1;
        @(posedge frame_clk); #1;
        rst_n = 1'b1;

        frame(4'b0000, 1'b0, 300, 460, "serve_track");
        frame(4'b0000, 1'b0, 200, 20,  "serve_sat");
        frame(4'b0000, 1'b0, 320, 460, "serve_ready");
        frame(4'b0000, 1'b1, 320, 460, "launch");
        frame(4'b0000, 1'b1, 320, 460, "launch_held");
        repeat (4) frame(4'b0000, 1'b0, 100, 100, "move_free");
        frame(4'b0100, 1'b0, 100, 100, "right_flip");
        repeat (2) frame(4'b0100, 1'b0, 100, 100, "right_held");

        for (int i = 0; i < 300 && m_y > RADIUS; i++) frame(4'b0000, 1'b0, 100, 100, "climb");
        check("climb_bound", 32'(m_y == RADIUS), 32'd1);
        repeat (3) frame(4'b0000, 1'b0, 100, 100, "top_clamp");
        frame(4'b1010, 1'b0, 100, 100, "corner_left_up");
        frame(4'b1000, 1'b1, 100, 100, "opposing_left");

        for (int i = 0; i < 300 && m_y < FLOOR; i++) frame(4'b0000, 1'b0, 100, 100, "descend");
        check("descend_bound", 32'(m_y >= FLOOR), 32'd1);
        frame(4'b0001, 1'b0, 100, 100, "floor_lost");
        frame(4'b0000, 1'b0, 250, 300, "lost_to_serve");
        frame(4'b0000, 1'b0, 260, 310, "serve_after_lost");

        lose_ball();
        lose_ball();
        repeat (3) frame(4'b1111, 1'b0, $urandom_range(0, 1023), $urandom_range(0, 1023), "over_hold");
        frame(4'b0000, 1'b1, 400, 450, "restart");
        frame(4'b0000, 1'b0, 410, 450, "restart_serve");

        frame(4'b0000, 1'b1, 410, 450, "launch2");
        repeat (3) frame(4'b0000, 1'b0, 410, 450, "move2");
        frame(4'b0100, 1'b0, 410, 450, "bounce_before_reset");
        reset_now("async_reset");
        frame(4'b0000, 1'b0, 300, 460, "post_reset_serve");
        frame(4'b0000, 1'b1, 300, 460, "post_reset_launch");
        frame(4'b0000, 1'b0, 300, 460, "post_reset_move");

        for (int i = 0; i < 600; i++) begin
            logic [3:0] c;
            bit         l;
            c = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
            l = ($urandom_range(0, 7) == 0);
            frame(c, l, $urandom_range(0, 1023), $urandom_range(0, 1023), "random");
        end

        @(negedge frame_clk);
        #1;
        check("scoreboard_drain", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ball_motion.md
# ball_motion

Ball motion controller for the breakout game. Each frame it advances the ball position, reverses direction on the collision flags from the crash detector, and handles serve, life loss and game over. Its ball coordinates feed the crash detector and the renderer, and it consumes the crash detector's `{left,right,up,down}` flags, which closes the position→collision→position loop.

## Interface
Parameters:
- STEP, 2: pixels moved per frame on each axis.
- START_LIVES, 3: lives loaded at reset and on restart. Range 1–3.
- COOLDOWN, 2: frames during which a reversed axis ignores further crash flags.
- BALL_RADIUS, 10: ball radius in pixels.
- SCREEN_W, 640: screen width in pixels.
- SCREEN_H, 480: screen height in pixels.
- FLOOR_Y, 470: ball y at or beyond which a downward ball is lost.

Ports:
- iFrame_CLK  in  1  frame clock; one tick per video frame.
- iRST_n  in  1  asynchronous, active-low reset.
- iCrash  in  4  collision flags `{left,right,up,down}`, sampled each frame.
- iLaunch  in  1  serve / restart request, level-sampled.
- iSlider_x  in  10  slider centre x.
- iSlider_y  in  10  slider centre y.
- oBall_x  out  10  ball centre x.
- oBall_y  out  10  ball centre y.
- oLives  out  2  remaining lives.
- oServing  out  1  high in SERVE.
- oGame_over  out  1  high in OVER.
- oBounce  out  1  one-frame pulse on any accepted reversal, for sound.

Reset is `iRST_n`, asynchronous, active-low. The clock is `iFrame_CLK`.

## Operation
- State machine: SERVE, MOVE, LOST, OVER.
- Direction: `dir_x` and `dir_y` are each ±1.

SERVE:
- `oBall_x = iSlider_x`.
- `oBall_y = iSlider_y - 31`, saturating at BALL_RADIUS.
- On iLaunch=1: set `dir_x=+1`, `dir_y=-1`, clear cooldowns, go to MOVE.

MOVE, per frame, x axis:
- left=1 with `dir_x=-1` and `cool_x=0`: set `dir_x=+1`, load `cool_x=COOLDOWN`.
- right=1 with `dir_x=+1` and `cool_x=0`: set `dir_x=-1`, load `cool_x=COOLDOWN`.
- left and right both 1: `dir_x` is unchanged and no cooldown is loaded.
- A flag that opposes the current direction is ignored.
- If `cool_x>0` and no reversal occurs this frame, `cool_x` decrements.

MOVE, per frame, y axis:
- Same rules using up and down against `dir_y`.

MOVE, floor check:
- If `oBall_y >= FLOOR_Y` and `dir_y=+1`, go to LOST.
- The floor check overrides down-flag handling; the position is held this frame.

MOVE, position update:
- Computed in 11-bit signed arithmetic using the new direction.
- `x` is clamped to [BALL_RADIUS, SCREEN_W-BALL_RADIUS].
- `y` is clamped to [BALL_RADIUS, SCREEN_H-BALL_RADIUS].

MOVE, bounce pulse:
- `oBounce=1` for one frame when any axis reverses.

LOST:
- Lives decrement, saturating at 0.
- If the new value is 0, go to OVER; otherwise go to SERVE.

OVER:
- Position is held.
- On iLaunch=1: `oLives=START_LIVES`, go to SERVE.

## Timing
- All outputs are registered and update on the rising edge of iFrame_CLK.
- Latency: iCrash in frame n affects `oBall_*` at edge n+1.

Reset values:
- State SERVE.
- `oBall_x=320`, `oBall_y=400`.
- `dir_x=+1`, `dir_y=-1`.
- `oLives=START_LIVES`.
- `oServing=1`, `oGame_over=0`, `oBounce=0`.
- Cooldowns 0.

Reset mid-MOVE or mid-LOST returns immediately to the reset values. No pending decrement survives reset.

Transition timing:
- iLaunch held high through SERVE→MOVE has no further effect.
- iLaunch is ignored in MOVE and LOST.
- LOST lasts exactly one frame.
- The first SERVE frame after reset or LOST already tracks the slider.

Corner case: with left and up asserted in the same frame, both axes reverse and a single `oBounce` pulse is produced.

## Structure
- Shared settings package holds:
  - screen constants, BALL_RADIUS, FLOOR_Y, reset position;
  - the state encoding (SERVE=0, MOVE=1, LOST=2, OVER=3).
- Sub-module `axis_bounce`, instantiated twice (x and y). Each instance handles:
  - inputs: negative-side flag, positive-side flag, enable;
  - state: direction, cooldown counter;
  - outputs: clamped next position and a reversal pulse.
- The top level contains the state machine, lives counter, serve tracking, floor check and the `oBounce` OR.

## Test plan
- Reset, then slider at (300,460) with no launch → ball (300,429), oServing=1, oLives=3.
- Launch from (320,429), then no crashes for 5 frames → ball (330,419).
- Right flag with `dir_x=+1` → next x decreases by 2, oBounce=1 for one frame. Right flag held 2 more frames → no second reversal.
- Ball at y=470 moving down with down=1 → LOST; next frame SERVE with oLives=2.
- Three losses → oGame_over=1, position frozen. iLaunch → SERVE with oLives=3.
- iRST_n low mid-MOVE at (500,200) → asynchronously (320,400), state SERVE, oBounce=0.
